rgbw_frame_sched: RTL and testbench



---
 rtl/rgbw_pkg.sv | 41 ++++
 rtl/rgbw_convert.sv | 41 ++++
 rtl/rgbw_frame_sched.sv | 165 ++++++++++++++++
 tb/tb_rgbw_frame_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW frame scheduler: input word layout,
// output word layout, FSM state encoding and default timing.
package rgbw_pkg;

  // Input word from the serial-input FIFO
  localparam int IN_VALID        = 31;
  localparam int IN_STREAM_RESET = 30;
  localparam int IN_G_HI = 23;
  localparam int IN_G_LO = 16;
  localparam int IN_R_HI = 15;
  localparam int IN_R_LO = 8;
  localparam int IN_B_HI = 7;
  localparam int IN_B_LO = 0;

  // Output word to the RGBW transmitter
  localparam int OUT_G_LO = 24;
  localparam int OUT_R_LO = 16;
  localparam int OUT_B_LO = 8;
  localparam int OUT_W_LO = 0;

  // 80 us at 96 MHz
  localparam int DEF_LATCH_CYCLES = 7680;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_DECODE,
    ST_CONV,
    ST_SEND,
    ST_TXWAIT,
    ST_LATCH
  } state_t;

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/rgbw_convert.sv
// Registered one-cycle RGB to RGBW conversion.
// RGBW_WHITE_EXTRACT_EN defined: white = min(R,G,B), subtracted from each
// colour. Undefined: white = 0 and colours pass straight through.
module rgbw_convert
  import rgbw_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  g,
  input  logic [7:0]  r,
  input  logic [7:0]  b,
  output logic [31:0] rgbw
);

  logic [7:0]  w;
  logic [31:0] rgbw_nxt;

  // Combinational colour split; subtraction cannot underflow since w is the minimum
  always_comb begin
`ifdef RGBW_WHITE_EXTRACT_EN
    w = min3(g, r, b);
`else
    w = 8'h00;
`endif
    rgbw_nxt = 32'h0;
    rgbw_nxt[OUT_G_LO +: 8] = g - w;
    rgbw_nxt[OUT_R_LO +: 8] = r - w;
    rgbw_nxt[OUT_B_LO +: 8] = b - w;
    rgbw_nxt[OUT_W_LO +: 8] = w;
  end

  // Result register: one cycle of latency in both build variants
  always_ff @(posedge clk) begin
    if (!rst_n)
      rgbw <= 32'h0;
    else if (load)
      rgbw <= rgbw_nxt;
  end

endmodule

// File: rtl/rgbw_frame_sched.sv
// Frame scheduler between the serial-input word FIFO and the RGBW
// transmitter. Optional white extraction via RGBW_WHITE_EXTRACT_EN
// (implemented in rgbw_convert).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for a FIFO word, pop it
// POP       | FIFO read data arrives, capture it
// DECODE    | drop invalid / overflow words, stream reset -> LATCH
// CONV      | converter busy for one cycle, result into tx_word
// SEND      | wait for tx_ready, issue tx_start
// TXWAIT    | guard cycle, then wait for transmitter idle
// LATCH     | wait for last pixel out, then timed latch gap
module rgbw_frame_sched
  import rgbw_pkg::*;
#(
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int MAX_PIXELS   = 256,
  parameter int PIX_W        = 9
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      fifo_rd_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [31:0]      tx_word,
  output logic             latch_active,
  output logic             frame_done,
  output logic [PIX_W-1:0] pixel_count,
  output logic             frame_err
);

  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(MAX_PIXELS);

  state_t           state, state_nxt;
  logic [31:0]      word_q;
  logic [PIX_W-1:0] pix_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             lat_run;
  logic [31:0]      conv_rgbw;

  logic fifo_rd_c, conv_load, start_set, err_set, lat_start, lat_end;
  logic unused_bits;

  // Bits between the flags and the colour fields carry nothing
  assign unused_bits = ^word_q[29:24];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    fifo_rd_c = 1'b0;
    conv_load = 1'b0;
    start_set = 1'b0;
    err_set   = 1'b0;
    lat_start = 1'b0;
    lat_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_c = 1'b1;
          state_nxt = ST_POP;
        end
      end
      ST_POP:    state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (!word_q[IN_VALID]) begin
          state_nxt = ST_IDLE;
        end else if (word_q[IN_STREAM_RESET]) begin
          // non-zero payload marks a reset forced by FIFO-full upstream
          err_set   = |word_q[IN_G_HI:IN_B_LO];
          state_nxt = ST_LATCH;
        end else if (pix_cnt == PIX_MAX) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          conv_load = 1'b1;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV:   state_nxt = ST_SEND;
      ST_SEND: begin
        if (tx_ready) begin
          start_set = 1'b1;
          state_nxt = ST_TXWAIT;
        end
      end
      ST_TXWAIT: begin
        // tx_start is high exactly on the guard cycle, so it masks tx_ready
        if (!tx_start && tx_ready)
          state_nxt = ST_IDLE;
      end
      ST_LATCH: begin
        if (!lat_run) begin
          lat_start = tx_ready;
        end else if (lat_cnt == '0) begin
          lat_end   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Gated so no word is popped while reset is held
  assign fifo_rd      = fifo_rd_c & rst_n;
  assign latch_active = lat_run;
  assign frame_done   = lat_end;

  rgbw_convert u_convert (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (conv_load),
    .g     (word_q[IN_G_HI:IN_G_LO]),
    .r     (word_q[IN_R_HI:IN_R_LO]),
    .b     (word_q[IN_B_HI:IN_B_LO]),
    .rgbw  (conv_rgbw)
  );

  // Datapath: word capture, tx handshake, pixel counter, latch down-counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q      <= 32'h0;
      pix_cnt     <= '0;
      lat_cnt     <= '0;
      lat_run     <= 1'b0;
      tx_start    <= 1'b0;
      tx_word     <= 32'h0;
      pixel_count <= '0;
      frame_err   <= 1'b0;
    end else begin
      tx_start <= start_set;
      if (state == ST_POP)
        word_q <= fifo_rd_data;
      if (state == ST_CONV)
        tx_word <= conv_rgbw;
      if (start_set && pix_cnt != PIX_MAX)
        pix_cnt <= pix_cnt + 1'b1;
      if (err_set)
        frame_err <= 1'b1;
      if (lat_start) begin
        lat_run <= 1'b1;
        lat_cnt <= LAT_W'(LATCH_CYCLES - 1);
      end else if (lat_end) begin
        lat_run     <= 1'b0;
        pixel_count <= pix_cnt;
        pix_cnt     <= '0;
      end else if (lat_run) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgbw_frame_sched.sv
// Directed bench for rgbw_frame_sched: FIFO and transmitter models,
// table-driven pixel vectors plus hand-written frame sequences.
module tb_rgbw_frame_sched;

  localparam int LATCH = 7680;
  localparam int MAXP  = 4;
  localparam int PW    = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   fifo_rd_data = 32'h0;
  logic          fifo_empty;
  logic          fifo_rd;
  logic          tx_ready;
  logic          tx_start;
  logic [31:0]   tx_word;
  logic          latch_active;
  logic          frame_done;
  logic [PW-1:0] pixel_count;
  logic          frame_err;

  always #5 clk = ~clk;

  rgbw_frame_sched #(.LATCH_CYCLES(LATCH), .MAX_PIXELS(MAXP), .PIX_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .tx_ready     (tx_ready),
    .tx_start     (tx_start),
    .tx_word      (tx_word),
    .latch_active (latch_active),
    .frame_done   (frame_done),
    .pixel_count  (pixel_count),
    .frame_err    (frame_err)
  );

  // FIFO model: bench writes, DUT pops, registered read data
  logic [31:0] fmem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rd_data <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  // Transmitter model: busy for 3 cycles after sampling tx_start
  int   busy = 0;
  logic hold_low;
  always @(posedge clk) begin
    if (tx_start) busy <= 3;
    else if (busy > 0) busy <= busy - 1;
  end
  assign tx_ready = (busy == 0) && !hold_low;

  // Monitor, sampled on the falling edge
  int          cyc = 0, n_rd = 0, n_start = 0, n_fd = 0, t_rd = 0, t_start = 0;
  int          la_run = 0, last_la_run = 0;
  logic [31:0] last_word = 32'h0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd) begin n_rd = n_rd + 1; t_rd = cyc; end
    if (tx_start) begin n_start = n_start + 1; t_start = cyc; last_word = tx_word; end
    if (frame_done) n_fd = n_fd + 1;
    if (latch_active) la_run = la_run + 1;
    else begin
      if (la_run != 0) last_la_run = la_run;
      la_run = 0;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_fd(input int target, input string nm);
    int k = 0;
    while (n_fd < target && k < 20000) begin @(negedge clk); k++; end
    check(nm, n_fd, target);
  endtask

  task automatic wait_start(input int target, input string nm);
    int k = 0;
    while (n_start < target && k < 500) begin @(negedge clk); k++; end
    check(nm, n_start, target);
  endtask

  typedef struct {
    logic [31:0] word;
    int          exp_starts;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vt [4];
  logic [31:0] w_first;
  int s0, r0, f0, l0;

  initial begin
`ifdef RGBW_WHITE_EXTRACT_EN
    w_first = 32'h00102010;
    vt[0] = '{32'h00FFFFFF, 0, 32'h00102010};
    vt[1] = '{32'h80FF8001, 1, 32'hFE7F0001};
    vt[2] = '{32'h40123456, 0, 32'hFE7F0001};
    vt[3] = '{32'h80AABBCC, 1, 32'h001122AA};
`else
    w_first = 32'h10203000;
    vt[0] = '{32'h00FFFFFF, 0, 32'h10203000};
    vt[1] = '{32'h80FF8001, 1, 32'hFF800100};
    vt[2] = '{32'h40123456, 0, 32'hFF800100};
    vt[3] = '{32'h80AABBCC, 1, 32'hAABBCC00};
`endif
    rst_n    = 1'b0;
    hold_low = 1'b0;
    tick(3);
    check("rst fifo_rd", fifo_rd, 0);
    check("rst tx_start", tx_start, 0);
    check("rst latch_active", latch_active, 0);
    check("rst frame_done", frame_done, 0);
    check("rst tx_word", tx_word, 0);
    check("rst pixel_count", pixel_count, 0);
    check("rst frame_err", frame_err, 0);
    rst_n = 1'b1;
    tick(2);

    // First pixel: latency from pop to tx_start and converted word
    push(32'h80102030);
    wait_start(1, "first start");
    check("rd to start latency", t_start - t_rd, 5);
    check("first tx_word", last_word, w_first);
    tick(20);

    // Table: invalid words dropped, valid ones converted
    for (int i = 0; i < 4; i++) begin
      s0 = n_start;
      push(vt[i].word);
      tick(30);
      check($sformatf("vec%0d starts", i), n_start - s0, vt[i].exp_starts);
      check($sformatf("vec%0d word", i), last_word, vt[i].exp_word);
    end

    // Stream reset ends frame of 3 pixels
    f0 = n_fd;
    push(32'hC0000000);
    wait_fd(f0 + 1, "frame1 done");
    tick(2);
    check("frame1 latch len", last_la_run, LATCH);
    check("frame1 pixel_count", pixel_count, 3);
    check("frame1 frame_err", frame_err, 0);

    // Back-to-back stream resets: two full gaps, empty frames
    f0 = n_fd;
    push(32'hC0000000);
    push(32'hC0000000);
    wait_fd(f0 + 2, "empty frames done");
    tick(2);
    check("empty latch len", last_la_run, LATCH);
    check("empty pixel_count", pixel_count, 0);
    check("empty frame_err", frame_err, 0);

    // tx_ready held low after a start with FIFO non-empty
    s0 = n_start;
    push(32'h80010203);
    wait_start(s0 + 1, "hold first start");
    hold_low = 1'b1;
    push(32'h80040506);
    push(32'hC0000000);
    r0 = n_rd;
    tick(100);
    check("hold no start", n_start - s0, 1);
    check("hold no pop", n_rd - r0, 0);
    hold_low = 1'b0;
    wait_start(s0 + 2, "hold second start");
    begin
      int k = 0;
      while (n_rd < r0 + 2 && k < 200) begin @(negedge clk); k++; end
    end
    hold_low = 1'b1;
    f0 = n_fd;
    l0 = last_la_run;
    tick(100);
    check("latch waits active", latch_active, 0);
    check("latch waits run", la_run, 0);
    check("latch waits no done", n_fd - f0, 0);
    hold_low = 1'b0;
    wait_fd(f0 + 1, "hold frame done");
    tick(2);
    check("hold latch len", last_la_run, LATCH);
    check("hold pixel_count", pixel_count, 2);

    // Overflow: 6 pixels with MAX_PIXELS=4
    s0 = n_start;
    f0 = n_fd;
    for (int i = 0; i < 6; i++) push(32'h80000000 | (i + 1));
    push(32'hC0000000);
    wait_fd(f0 + 1, "ovf frame done");
    tick(2);
    check("ovf starts", n_start - s0, 4);
    check("ovf pixel_count", pixel_count, 4);
    check("ovf frame_err", frame_err, 1);

    // Reset pulse partway through the latch gap
    push(32'h80010203);
    push(32'hC0000000);
    begin
      int k = 0;
      while (la_run < 3000 && k < 10000) begin @(negedge clk); k++; end
      check("reached latch 3000", (la_run >= 3000), 1);
    end
    f0 = n_fd;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort latch_active", latch_active, 0);
    check("abort frame_done", frame_done, 0);
    check("abort pixel_count", pixel_count, 0);
    check("abort frame_err", frame_err, 0);
    check("abort tx_word", tx_word, 0);
    rst_n = 1'b1;
    tick(LATCH + 200);
    check("abort no done", n_fd - f0, 0);
    check("abort idle latch", latch_active, 0);

    // Next frame after reset: counter restarted, flagged stream reset
    s0 = n_start;
    push(32'h80050505);
    push(32'hC0000100);
    wait_fd(f0 + 1, "final frame done");
    tick(2);
    check("final starts", n_start - s0, 1);
    check("final pixel_count", pixel_count, 1);
    check("final frame_err", frame_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
